mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: word address width.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 Parameter FMT_WORD, default 2'b11: data_format code for a full-word access.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 i_req_i  in  1  instruction fetch request.
REQ-008 i_addr_i  in  ADDR_W  fetch address.
REQ-009 i_gnt_o  out  1  fetch accepted this cycle.
REQ-010 i_rvalid_o  out  1  fetch data valid.
REQ-011 i_rdata_o  out  DATA_W  fetch data.
REQ-012 d_req_i / d_we_i  in  1 / 1  data request / write enable.
REQ-013 d_addr_i / d_wdata_i  in  ADDR_W / DATA_W  data address / write data.
REQ-014 d_format_i / d_sign_i  in  2 / 1  access size / sign-extend.
REQ-015 d_gnt_o / d_rvalid_o  out  1 / 1  data accepted / read data valid.
REQ-016 d_rdata_o  out  DATA_W  data read result.
REQ-017 mem_en_o, mem_we_o, mem_sign_o  out  1  shared single-port memory controls.
REQ-018 mem_addr_o / mem_din_o / mem_format_o  out  ADDR_W / DATA_W / 2  memory address, write data, size.
REQ-019 mem_dout_i  in  DATA_W  memory read data, valid one cycle after a read enable.
REQ-020 conflict_cnt_o  out  16  count of cycles with both requests high.

Function
REQ-021 Grant SHALL be combinational: at most one of i_gnt_o/d_gnt_o high per cycle; a requester holds req and payload until its gnt.
REQ-022 mem_en_o SHALL equal i_gnt_o OR d_gnt_o; memory outputs SHALL be muxed from the granted port in the same cycle.
REQ-023 Instruction grant SHALL drive mem_we_o=0, mem_format_o=FMT_WORD, mem_sign_o=0, mem_din_o=0.
REQ-024 A single requester SHALL be granted immediately; grants may occur every cycle (back-to-back).
REQ-025 Pending-read FSM states IDLE, RD_I, RD_D: next state RD_I after instruction grant, RD_D after data read grant, IDLE otherwise (incl. data write).
REQ-026 In RD_I i_rvalid_o=1; in RD_D d_rvalid_o=1; exactly one cycle after the grant; writes SHALL produce no rvalid.
REQ-027 i_rdata_o and d_rdata_o SHALL both be driven from mem_dout_i; only rvalid qualifies them.
REQ-028 Response of grant N and new grant N+1 SHALL coexist in one cycle without stall.
REQ-029 conflict_cnt_o SHALL increment each cycle with i_req_i and d_req_i both high, saturating at 16'hFFFF.

Reset
REQ-030 On rst_ni low: FSM=IDLE, rvalids=0, conflict_cnt_o=0, round-robin pointer=instruction-last, immediately and asynchronously.
REQ-031 A read response pending at reset SHALL be discarded; grants SHALL be 0 while rst_ni low.

Configuration
REQ-032 Macro MEM_ARB_ROUND_ROBIN_EN: defined -> on conflict the port not granted last wins, pointer updated on every grant; undefined -> data port always wins conflicts, no pointer register.

Verification
REQ-033 Only i_req_i, addr 0x04, mem word 0x12345678 -> i_gnt_o same cycle, i_rvalid_o next cycle, i_rdata_o=0x12345678.
REQ-034 d write addr 0x10 data 0xCAFEBABE, then d read 0x10 -> gnt both cycles, no rvalid after write, d_rvalid_o with 0xCAFEBABE after read.
REQ-035 Both requests held 4 cycles, macro undefined -> d_gnt_o 4 cycles, i_gnt_o 0, conflict_cnt_o=4.
REQ-036 Both requests held 4 cycles, macro defined -> grants D,I,D,I, conflict_cnt_o=4 (request dropped after each grant's reload by bench as needed).
REQ-037 Instruction read granted, rst_ni pulsed low next cycle -> no i_rvalid_o, conflict_cnt_o=0, first post-reset grant normal.
REQ-038 Hold both requests 70000 cycles -> conflict_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch port and a data port.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for alternating priority on conflicts (default: data port wins).
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter logic [1:0]  FMT_WORD = 2'b11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [1:0]        d_format_i,
    input  logic              d_sign_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic              mem_sign_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic [1:0]        mem_format_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic [15:0]       conflict_cnt_o
);

    // State bit 0 / bit 1 double as the fetch / data rvalid outputs.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_I = 2'b01,
        RD_D = 2'b10
    } rd_state_e;

    rd_state_e   state_r;
    logic [15:0] conflict_cnt_r;
    logic        i_gnt_s;
    logic        d_gnt_s;
    logic        d_wins_s;
    logic        conflict_s;

    assign conflict_s = i_req_i & d_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_r;

    // Conflict winner: the port that was not granted most recently.
    always_comb begin
        if (last_d_r) begin
            d_wins_s = 1'b0;
        end else begin
            d_wins_s = 1'b1;
        end
    end

    // Remember which port took the last grant; reset means "instruction was last".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_d_r <= 1'b0;
        end else if (d_gnt_s) begin
            last_d_r <= 1'b1;
        end else if (i_gnt_s) begin
            last_d_r <= 1'b0;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    assign d_wins_s = 1'b1;
`endif

    // Combinational grant; held off entirely while reset is asserted.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst_ni) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (conflict_s) begin
            d_gnt_s = d_wins_s;
            i_gnt_s = ~d_wins_s;
        end else begin
            d_gnt_s = d_req_i;
            i_gnt_s = i_req_i;
        end
    end

    // Memory port mux: fetches are always full-word unsigned reads.
    always_comb begin
        mem_we_o     = 1'b0;
        mem_sign_o   = 1'b0;
        mem_format_o = FMT_WORD;
        mem_addr_o   = {ADDR_W{1'b0}};
        mem_din_o    = {DATA_W{1'b0}};
        if (i_gnt_s) begin
            mem_we_o     = 1'b0;
            mem_sign_o   = 1'b0;
            mem_format_o = FMT_WORD;
            mem_addr_o   = i_addr_i;
            mem_din_o    = {DATA_W{1'b0}};
        end else if (d_gnt_s) begin
            mem_we_o     = d_we_i;
            mem_sign_o   = d_sign_i;
            mem_format_o = d_format_i;
            mem_addr_o   = d_addr_i;
            mem_din_o    = d_wdata_i;
        end else begin
            mem_we_o     = 1'b0;
            mem_sign_o   = 1'b0;
            mem_format_o = FMT_WORD;
            mem_addr_o   = {ADDR_W{1'b0}};
            mem_din_o    = {DATA_W{1'b0}};
        end
    end

    // Pending-read tracker: the response cycle always follows the grant cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else if (i_gnt_s) begin
            state_r <= RD_I;
        end else if (d_gnt_s && !d_we_i) begin
            state_r <= RD_D;
        end else begin
            state_r <= IDLE;
        end
    end

    // Saturating count of cycles where both ports are requesting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_r <= 16'h0000;
        end else if (conflict_s && (conflict_cnt_r != 16'hFFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign i_gnt_o        = i_gnt_s;
    assign d_gnt_o        = d_gnt_s;
    assign mem_en_o       = i_gnt_s | d_gnt_s;
    assign i_rvalid_o     = state_r[0];
    assign d_rvalid_o     = state_r[1];
    assign i_rdata_o      = mem_dout_i;
    assign d_rdata_o      = mem_dout_i;
    assign conflict_cnt_o = conflict_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized + directed bench with a word-level memory model and response scoreboard.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam logic [1:0]  FMT_WORD = 2'b11;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_gnt_o, i_rvalid_o;
    logic [DATA_W-1:0] i_rdata_o;
    logic              d_req_i, d_we_i, d_sign_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [1:0]        d_format_i;
    logic              d_gnt_o, d_rvalid_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              mem_en_o, mem_we_o, mem_sign_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_din_o;
    logic [1:0]        mem_format_o;
    logic [DATA_W-1:0] mem_dout_i;
    logic [15:0]       conflict_cnt_o;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FMT_WORD(FMT_WORD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
        .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_format_i(d_format_i), .d_sign_i(d_sign_i), .d_gnt_o(d_gnt_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_sign_o(mem_sign_o),
        .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_format_o(mem_format_o),
        .mem_dout_i(mem_dout_i), .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Environment memory (what the DUT talks to) and reference memory (bench's view).
    logic [DATA_W-1:0] env_mem [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) env_mem[mem_addr_o] <= mem_din_o;
            else          mem_dout_i <= env_mem[mem_addr_o];
        end
    end

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rsp_t;

    rsp_t i_q[$];
    rsp_t d_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   cnt_m = 0;
    bit   last_d_m = 1'b0;
    bit   i_seen = 1'b0;
    bit   d_seen = 1'b0;
    int   i_tally = 0;
    int   d_tally = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        bit exp_i, exp_d, exp_iv, exp_dv;
        cyc++;
        if (!rst_ni) begin
            check("rst_gnt", {62'd0, i_gnt_o, d_gnt_o}, 64'd0);
            check("rst_rvalid", {62'd0, i_rvalid_o, d_rvalid_o}, 64'd0);
            check("rst_cnt", {48'd0, conflict_cnt_o}, 64'd0);
            i_q.delete();
            d_q.delete();
            cnt_m    = 0;
            last_d_m = 1'b0;
            i_seen   = 1'b0;
            d_seen   = 1'b0;
        end else begin
            exp_iv = (i_q.size() > 0) && (i_q[0].due == cyc);
            exp_dv = (d_q.size() > 0) && (d_q[0].due == cyc);
            check("i_rvalid", {63'd0, i_rvalid_o}, {63'd0, exp_iv});
            check("d_rvalid", {63'd0, d_rvalid_o}, {63'd0, exp_dv});
            if (exp_iv) begin
                check("i_rdata", {32'd0, i_rdata_o}, {32'd0, i_q[0].data});
                void'(i_q.pop_front());
            end
            if (exp_dv) begin
                check("d_rdata", {32'd0, d_rdata_o}, {32'd0, d_q[0].data});
                void'(d_q.pop_front());
            end

            check("conflict_cnt", {48'd0, conflict_cnt_o}, 64'(cnt_m));
            if (i_req_i && d_req_i && cnt_m < 65535) cnt_m++;

            if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                exp_d = !last_d_m;
`else
                exp_d = 1'b1;
`endif
                exp_i = !exp_d;
            end else begin
                exp_d = d_req_i;
                exp_i = i_req_i;
            end
            check("grant", {62'd0, i_gnt_o, d_gnt_o}, {62'd0, exp_i, exp_d});
            if (exp_d) last_d_m = 1'b1;
            else if (exp_i) last_d_m = 1'b0;

            if (exp_i) begin
                check("mem_i", {19'd0, mem_en_o, mem_we_o, mem_sign_o, mem_format_o, mem_addr_o, mem_din_o},
                      {19'd0, 1'b1, 1'b0, 1'b0, FMT_WORD, i_addr_i, 32'd0});
                i_q.push_back('{cyc + 1, ref_mem[i_addr_i]});
                i_tally++;
            end else if (exp_d) begin
                check("mem_d", {19'd0, mem_en_o, mem_we_o, mem_sign_o, mem_format_o, mem_addr_o, mem_din_o},
                      {19'd0, 1'b1, d_we_i, d_sign_i, d_format_i, d_addr_i, d_wdata_i});
                if (d_we_i) ref_mem[d_addr_i] = d_wdata_i;
                else        d_q.push_back('{cyc + 1, ref_mem[d_addr_i]});
                d_tally++;
            end else begin
                check("mem_idle", {63'd0, mem_en_o}, 64'd0);
            end
            i_seen = i_gnt_o;
            d_seen = d_gnt_o;
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni  = 1'b0;
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        repeat (2) next_cycle();
        rst_ni = 1'b1;
    endtask

    // Stimulus: directed scenarios, then randomized traffic, then counter saturation.
    initial begin
        rst_ni = 1'b0; i_req_i = 1'b0; i_addr_i = 8'h00;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 8'h00; d_wdata_i = 32'h0;
        d_format_i = 2'b11; d_sign_i = 1'b0;
        for (int k = 0; k < 256; k++) begin
            env_mem[k] = $urandom;
            ref_mem[k] = env_mem[k];
        end
        env_mem[4] = 32'h12345678;
        ref_mem[4] = 32'h12345678;
        repeat (3) next_cycle();
        rst_ni = 1'b1;

        // Single fetch
        i_req_i = 1'b1; i_addr_i = 8'h04;
        next_cycle();
        i_req_i = 1'b0;
        repeat (2) next_cycle();

        // Data write then read-back of the same word
        d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 8'h10; d_wdata_i = 32'hCAFEBABE;
        next_cycle();
        d_we_i = 1'b0;
        next_cycle();
        d_req_i = 1'b0;
        repeat (2) next_cycle();

        // Four-cycle conflict from a fresh reset
        do_reset();
        i_tally = 0; d_tally = 0;
        i_req_i = 1'b1; i_addr_i = 8'h20;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h21;
        repeat (4) next_cycle();
        i_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i); #1;
        check("conflict4_cnt", {48'd0, conflict_cnt_o}, 64'd4);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("conflict4_dgnt", 64'(d_tally), 64'd2);
        check("conflict4_ignt", 64'(i_tally), 64'd2);
`else
        check("conflict4_dgnt", 64'(d_tally), 64'd4);
        check("conflict4_ignt", 64'(i_tally), 64'd0);
`endif
        next_cycle();

        // Fetch granted, reset hits before its response is sampled
        i_req_i = 1'b1; i_addr_i = 8'h04;
        next_cycle();
        rst_ni = 1'b0; i_addr_i = 8'h08;
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
        i_req_i = 1'b0;
        repeat (2) next_cycle();

        // Randomized traffic; each requester holds until granted
        for (int k = 0; k < 3000; k++) begin
            if (!i_req_i || i_seen) begin
                i_req_i  = ($urandom_range(0, 9) < 6);
                i_addr_i = 8'($urandom_range(0, 31));
            end
            if (!d_req_i || d_seen) begin
                d_req_i    = ($urandom_range(0, 9) < 6);
                d_we_i     = 1'($urandom_range(0, 1));
                d_addr_i   = 8'($urandom_range(0, 31));
                d_wdata_i  = $urandom;
                d_format_i = 2'($urandom_range(0, 3));
                d_sign_i   = 1'($urandom_range(0, 1));
            end
            next_cycle();
        end
        i_req_i = 1'b0; d_req_i = 1'b0;
        repeat (2) next_cycle();

        // Saturation of the conflict counter
        do_reset();
        i_req_i = 1'b1; i_addr_i = 8'h01;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 8'h02;
        repeat (70000) next_cycle();
        i_req_i = 1'b0; d_req_i = 1'b0;
        @(negedge clk_i); #1;
        check("sat_cnt", {48'd0, conflict_cnt_o}, 64'h0000_0000_0000_FFFF);

        repeat (3) next_cycle();
        check("drain", 64'(i_q.size() + d_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
